// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between a 1-byte register-file requester and a
// 2-byte ALU requester; round-robin arbitration and tx_busy handshaking.
module uart_tx_scheduler #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rf_valid,
  input  logic [DATA_WIDTH-1:0]   rf_data,
  output logic                    rf_ready,
  input  logic                    alu_valid,
  input  logic [2*DATA_WIDTH-1:0] alu_data,
  output logic                    alu_ready,
  input  logic                    tx_busy,
  output logic                    tx_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    sched_busy
);

  localparam int unsigned CNT_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] w_tx_data_next;
  logic [DATA_WIDTH-1:0] r_hi_byte;
  logic [DATA_WIDTH-1:0] w_hi_byte_next;
  logic [1:0]            r_byte_cnt;
  logic [1:0]            w_byte_cnt_next;
  logic                  r_byte_idx;
  logic                  w_byte_idx_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  r_last_alu;
  logic                  w_last_alu_next;
  logic                  w_grant_rf;
  logic                  w_grant_alu;

  // Round-robin: on contention the requester that was not served last wins.
  assign w_grant_rf  = rf_valid & (~alu_valid | r_last_alu);
  assign w_grant_alu = alu_valid & ~w_grant_rf;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  assign tx_data    = r_tx_data;
  assign sched_busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tx_data_next  = r_tx_data;
    w_hi_byte_next  = r_hi_byte;
    w_byte_cnt_next = r_byte_cnt;
    w_byte_idx_next = r_byte_idx;
    w_cnt_next      = r_cnt;
    w_last_alu_next = r_last_alu;
    rf_ready        = 1'b0;
    alu_ready       = 1'b0;
    tx_valid        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_grant_rf) begin
          rf_ready        = 1'b1;
          w_tx_data_next  = rf_data;
          w_hi_byte_next  = '0;
          w_byte_cnt_next = 2'd1;
          w_byte_idx_next = 1'b0;
          w_last_alu_next = 1'b0;
          w_state_next    = S_ISSUE;
        end else if (w_grant_alu) begin
          alu_ready       = 1'b1;
          w_tx_data_next  = alu_data[DATA_WIDTH-1:0];
          w_hi_byte_next  = alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
          w_byte_cnt_next = 2'd2;
          w_byte_idx_next = 1'b0;
          w_last_alu_next = 1'b1;
          w_state_next    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!tx_busy) begin
          tx_valid     = 1'b1;
          w_cnt_next   = '0;
          w_state_next = S_WAIT_HI;
        end
      end

      // A strobe the UART never acknowledged is re-issued after the timeout.
      S_WAIT_HI: begin
        if (tx_busy) begin
          w_state_next = S_WAIT_LO;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
            w_state_next = S_ISSUE;
          end
        end
      end

      S_WAIT_LO: begin
        if (!tx_busy) begin
          if ((r_byte_idx == 1'b0) && (r_byte_cnt == 2'd2)) begin
            w_byte_idx_next = 1'b1;
            w_tx_data_next  = r_hi_byte;
            w_state_next    = S_ISSUE;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end

      default: begin
        w_state_next    = S_IDLE;
        w_tx_data_next  = '0;
        w_hi_byte_next  = '0;
        w_byte_cnt_next = 2'd0;
        w_byte_idx_next = 1'b0;
        w_cnt_next      = '0;
        w_last_alu_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_data  <= '0;
      r_hi_byte  <= '0;
      r_byte_cnt <= 2'd0;
      r_byte_idx <= 1'b0;
      r_cnt      <= '0;
      r_last_alu <= 1'b1;
    end else begin
      r_tx_data  <= w_tx_data_next;
      r_hi_byte  <= w_hi_byte_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_byte_idx <= w_byte_idx_next;
      r_cnt      <= w_cnt_next;
      r_last_alu <= w_last_alu_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected bytes are queued at stimulus
// time and matched against every tx_valid strobe; a small UART model drives tx_busy.
module tb_uart_tx_scheduler;

  localparam int unsigned DW       = 8;
  localparam int unsigned TO       = 15;
  localparam int          BUSY_LEN = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rf_valid = 1'b0;
  logic [DW-1:0] rf_data = '0;
  logic          rf_ready;
  logic          alu_valid = 1'b0;
  logic [2*DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          tx_busy = 1'b0;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          sched_busy;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int cyc      = 0;
  logic [DW-1:0] sb_q[$];
  int pulse_cyc[$];
  bit pulse_seen = 1'b0;
  int busy_left  = 0;
  int busy_skip  = 0;
  bit stuck      = 1'b0;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rf_valid   (rf_valid),
    .rf_data    (rf_data),
    .rf_ready   (rf_ready),
    .alu_valid  (alu_valid),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .tx_busy    (tx_busy),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .sched_busy (sched_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rf_ready || alu_ready)
      check("one_ready", 32'(rf_ready & alu_ready), 32'd0);
    if (tx_valid === 1'b1) begin
      n_pulses++;
      pulse_cyc.push_back(cyc);
      pulse_seen = 1'b1;
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check("tx_data", 32'(tx_data), 32'(sb_q.pop_front()));
    end
  end

  // UART model: busy for BUSY_LEN cycles after a strobe, optionally ignoring strobes.
  initial forever begin
    @(posedge clk);
    #1;
    if (pulse_seen) begin
      pulse_seen = 1'b0;
      if (busy_skip > 0) busy_skip--;
      else busy_left = BUSY_LEN;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    tx_busy = stuck || (busy_left > 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      #1;
      if (!sched_busy) break;
    end
    check("idle_reached", 32'(sched_busy), 32'd0);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      #1;
      if (n_pulses >= target) break;
    end
    check("pulse_wait", 32'(n_pulses >= target), 32'd1);
  endtask

  task automatic wait_grant(input int budget, output logic got_alu, output logic ok);
    ok = 1'b0;
    got_alu = 1'b0;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (rf_ready || alu_ready) begin
        ok = 1'b1;
        got_alu = alu_ready;
        break;
      end
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_rf_ready"}, 32'(rf_ready), 32'd0);
    check({tag, "_alu_ready"}, 32'(alu_ready), 32'd0);
    check({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
  endtask

  initial begin
    int base;
    logic got_alu, ok;
    int exp_alu[3];
    exp_alu = '{0, 1, 0};

    // Reset state, then single RF byte
    repeat (3) tick();
    #1;
    check_reset_outputs("rst");
    tick();
    reset = 1'b1;
    tick();
    base = n_pulses;
    rf_valid = 1'b1;
    rf_data  = 8'hA5;
    sb_q.push_back(8'hA5);
    #1;
    check("t1_rf_ready", 32'(rf_ready), 32'd1);
    check("t1_alu_ready", 32'(alu_ready), 32'd0);
    check("t1_idle", 32'(sched_busy), 32'd0);
    tick();
    rf_valid = 1'b0;
    #1;
    check("t1_latency_valid", 32'(tx_valid), 32'd1);
    check("t1_latency_data", 32'(tx_data), 32'hA5);
    check("t1_rf_ready_drop", 32'(rf_ready), 32'd0);
    check("t1_sched_busy", 32'(sched_busy), 32'd1);
    wait_idle(60);
    check("t1_pulses", 32'(n_pulses - base), 32'd1);

    // ALU word, low byte first
    tick();
    base = n_pulses;
    alu_valid = 1'b1;
    alu_data  = 16'h12C4;
    sb_q.push_back(8'hC4);
    sb_q.push_back(8'h12);
    #1;
    check("t2_alu_ready", 32'(alu_ready), 32'd1);
    check("t2_rf_ready", 32'(rf_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    wait_idle(80);
    check("t2_pulses", 32'(n_pulses - base), 32'd2);
    check("t2_data_hold", 32'(tx_data), 32'h12);

    // Contention from reset: RF, ALU, RF
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    base = n_pulses;
    rf_valid  = 1'b1;
    rf_data   = 8'h5A;
    alu_valid = 1'b1;
    alu_data  = 16'h1234;
    sb_q.push_back(8'h5A);
    sb_q.push_back(8'h34);
    sb_q.push_back(8'h12);
    sb_q.push_back(8'h5A);
    for (int g = 0; g < 3; g++) begin
      wait_grant(300, got_alu, ok);
      check("t3_grant_seen", 32'(ok), 32'd1);
      check("t3_grant_order", 32'(got_alu), 32'(exp_alu[g]));
      tick();
    end
    rf_valid  = 1'b0;
    alu_valid = 1'b0;
    wait_idle(300);
    check("t3_pulses", 32'(n_pulses - base), 32'd4);

    // No busy acknowledge: periodic re-pulse of the same byte
    tick();
    busy_skip = 2;
    pulse_cyc.delete();
    base = n_pulses;
    rf_valid = 1'b1;
    rf_data  = 8'h3C;
    repeat (3) sb_q.push_back(8'h3C);
    #1;
    check("t4_rf_ready", 32'(rf_ready), 32'd1);
    tick();
    rf_valid = 1'b0;
    wait_pulses(base + 3, 120);
    wait_idle(100);
    check("t4_pulses", 32'(n_pulses - base), 32'd3);
    if (pulse_cyc.size() >= 3) begin
      check("t4_period1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(TO + 1));
      check("t4_period2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'(TO + 1));
    end

    // Reset between ALU bytes discards the high byte
    tick();
    base = n_pulses;
    alu_valid = 1'b1;
    alu_data  = 16'hBEEF;
    sb_q.push_back(8'hEF);
    #1;
    check("t5_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    wait_pulses(base + 1, 20);
    repeat (3) tick();
    #1;
    check("t5_in_transfer", 32'(sched_busy), 32'd1);
    check("t5_uart_busy", 32'(tx_busy), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("t5");
    tick();
    tick();
    reset = 1'b1;
    repeat (30) tick();
    check("t5_no_resume", 32'(n_pulses - base), 32'd1);
    check("t5_idle", 32'(sched_busy), 32'd0);

    // tx_busy already high in ISSUE holds off the strobe
    stuck = 1'b1;
    tick();
    tick();
    base = n_pulses;
    rf_valid = 1'b1;
    rf_data  = 8'h77;
    sb_q.push_back(8'h77);
    #1;
    check("t6_rf_ready", 32'(rf_ready), 32'd1);
    tick();
    rf_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t6_held_off", 32'(tx_valid), 32'd0);
      tick();
    end
    #1;
    stuck = 1'b0;
    wait_idle(80);
    check("t6_pulses", 32'(n_pulses - base), 32'd1);
    check("t6_data", 32'(tx_data), 32'h77);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequences the UART transmitter by sharing it between two requesters.
- Requester RF is the register-file read-response path and sends 1 byte per request.
- Requester ALU is the ALU result path and sends 16 bits as 2 bytes, low byte first.
- The block arbitrates between them, issues single-cycle tx_valid pulses and tracks tx_busy so bytes never overlap on the UART TX.

Parameters:
- DATA_WIDTH, 8, UART byte width; ALU result width is 2*DATA_WIDTH.
- BUSY_TIMEOUT, 15, cycles to wait for tx_busy to rise after a tx_valid pulse before re-issuing the pulse.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rf_valid  in  1  RF byte available
- rf_data  in  DATA_WIDTH  RF byte
- rf_ready  out  1  RF byte accepted this cycle
- alu_valid  in  1  ALU result available
- alu_data  in  2*DATA_WIDTH  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- tx_busy  in  1  UART TX busy; already synchronous to clk
- tx_valid  out  1  single-cycle byte strobe to UART TX
- tx_data  out  DATA_WIDTH  byte to UART TX
- sched_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: tx_valid=0, tx_data=0, rf_ready=0, alu_ready=0, sched_busy=0, state=IDLE, last_grant=ALU, byte index=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE, arbitration:
  - Only rf_valid high -> grant RF. Only alu_valid high -> grant ALU.
  - Both high -> round-robin: grant the requester that is not last_grant. The first contention after reset goes to RF.
  - The granted ready output is high combinationally in the same cycle (state==IDLE, requester valid, grant). At most one ready is high in any cycle.
  - On acceptance, capture payload into a holding register: RF byte, or full ALU word. Set byte count to 1 (RF) or 2 (ALU), update last_grant, go to ISSUE.
- ISSUE:
  - If tx_busy=0: drive tx_valid=1 for exactly this cycle, with tx_data = current byte (ALU: [7:0] first, then [15:8]). Clear timeout counter, go to WAIT_HI.
  - If tx_busy=1: hold in ISSUE with tx_valid=0.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. Each cycle without it, increment the counter. When the counter reaches BUSY_TIMEOUT, go back to ISSUE and re-pulse the same byte.
- WAIT_LO: wait for tx_busy=0. Then:
  - Remaining bytes -> advance byte index, go to ISSUE.
  - Otherwise -> go to IDLE.
- tx_data is registered and stays stable from ISSUE until the next byte is loaded or the block returns to IDLE. After IDLE it holds the last value.
- Latency: acceptance at cycle N gives tx_valid at cycle N+1 (if tx_busy=0).
- There is no back-to-back chaining during the UART stop bit. A new tx_valid is only issued after tx_busy is observed low.
- Requests arriving while not in IDLE are not accepted. Requesters must hold valid and payload until ready.
- A requester dropping valid before acceptance is not an error; nothing is recorded.
- Reset asserted mid-transfer returns everything immediately to reset values. The partially sent ALU word is discarded and not resumed.
- Unused or illegal state encodings recover to IDLE with outputs at reset values.

Test Plan:
- Reset release, then rf_valid=1, rf_data=0xA5, tx_busy low -> rf_ready high 1 cycle; tx_valid=1 with tx_data=0xA5 next cycle; model busy for 10 cycles -> return to IDLE, sched_busy=0.
- alu_valid=1, alu_data=0x12C4 -> first tx_valid with tx_data=0xC4; after busy fall, second tx_valid with tx_data=0x12; exactly 2 pulses total.
- rf_valid and alu_valid both held high from reset -> grant order RF, ALU, RF; tx byte sequence 0x5A, 0x34, 0x12, 0x5A for alu_data=0x1234, rf_data=0x5A.
- tx_busy never rises after the pulse -> tx_valid re-pulses with the same byte after BUSY_TIMEOUT+1 cycles, and again periodically until busy rises.
- Reset asserted in WAIT_LO between ALU bytes -> all outputs at reset values immediately; after release no further tx_valid until a new request.
- tx_busy already high in ISSUE (stuck for 5 cycles) -> no tx_valid until busy drops; then one pulse.
